// File: rtl/music_pkg.sv
// Shared constants for the music player and its note ROMs: widths, rest marker,
// note periods (clk cycles per full tone period at 50 MHz) and the sequencer state type.
package music_pkg;

  localparam int MP_ADDR_W   = 8;
  localparam int MP_NOTE_W   = 20;
  localparam int MP_REST_VAL = 2500;

  // 50e6 / f, rounded; a zero ROM entry marks the end of a song.
  localparam int NOTE_END = 0;
  localparam int NOTE_C4  = 191110;
  localparam int NOTE_D4  = 170264;
  localparam int NOTE_E4  = 151685;
  localparam int NOTE_F4  = 143172;
  localparam int NOTE_G4  = 127551;
  localparam int NOTE_A4  = 113636;
  localparam int NOTE_B4  = 101239;
  localparam int NOTE_C5  = 95557;
  localparam int NOTE_D5  = 85131;
  localparam int NOTE_E5  = 75843;
  localparam int NOTE_F5  = 71586;
  localparam int NOTE_G5  = 63776;
  localparam int NOTE_A5  = 56818;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    PAUSE
  } state_t;

endpackage

// File: rtl/music_player_tone_gen.sv
// Square-wave tone generator: holds the latched note period and the tone counter,
// and registers a 50% duty wave aligned with the cycle its inputs describe.
module tone_gen
  import music_pkg::*;
#(
  parameter int NOTE_W   = MP_NOTE_W,
  parameter int REST_VAL = MP_REST_VAL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [NOTE_W-1:0] period_in,
  input  logic              enable,
  input  logic              mute,
  output logic              wave,
  output logic              period_zero
);

  localparam logic [NOTE_W-1:0] REST = NOTE_W'(REST_VAL);

  logic [NOTE_W-1:0] period;
  logic [NOTE_W-1:0] tone_cnt;
  logic [NOTE_W-1:0] period_d;
  logic [NOTE_W-1:0] tone_d;
  logic [NOTE_W:0]   tone_inc;
  logic              wave_d;

  assign tone_inc    = {1'b0, tone_cnt} + {{NOTE_W{1'b0}}, 1'b1};
  assign period_zero = (period == '0);

  always_comb begin
    period_d = period;
    tone_d   = tone_cnt;
    if (load) begin
      period_d = period_in;
      tone_d   = '0;
    end else if (enable) begin
      if ((period == REST) || (tone_inc >= {1'b0, period})) begin
        tone_d = '0;
      end else begin
        tone_d = tone_inc[NOTE_W-1:0];
      end
    end
    // Wave is computed from the next counter values so the flop lines up with them.
    wave_d = !mute && (period_d != REST) && (tone_d < (period_d >> 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      period   <= '0;
      tone_cnt <= '0;
      wave     <= 1'b0;
    end else begin
      period   <= period_d;
      tone_cnt <= tone_d;
      wave     <= wave_d;
    end
  end

endmodule

// File: rtl/music_player.sv
// Beat sequencer for the per-song note ROMs driving a square-wave buzzer.
// Optional articulation gap at the end of each beat: define MUSIC_PLAYER_ARTICULATION_EN.
module music_player
  import music_pkg::*;
#(
  parameter int ADDR_W      = MP_ADDR_W,
  parameter int NOTE_W      = MP_NOTE_W,
  parameter int BEAT_CYCLES = 6250000,
  parameter int SONG_LEN    = 144,
  parameter int REST_VAL    = MP_REST_VAL,
  parameter int GAP_CYCLES  = 250000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pause,
  input  logic              loop_en,
  input  logic [NOTE_W-1:0] note,
  output logic [ADDR_W-1:0] addr,
  output logic              buzzer,
  output logic              playing,
  output logic              done
);

  localparam int BEAT_W = $clog2(BEAT_CYCLES);

  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_CYCLES - 1);
  localparam logic [BEAT_W-1:0] LOAD_BEAT = BEAT_W'(1);
  localparam logic [BEAT_W-1:0] TONE_BEAT = BEAT_W'(2);
  localparam logic [BEAT_W-1:0] GAP_BEAT  = BEAT_W'(BEAT_CYCLES - GAP_CYCLES);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);

`ifdef MUSIC_PLAYER_ARTICULATION_EN
  localparam bit ARTIC_EN = 1'b1;
`else
  localparam bit ARTIC_EN = 1'b0;
`endif

  state_t            state;
  state_t            state_d;
  logic [BEAT_W-1:0] beat_cnt;
  logic [BEAT_W-1:0] beat_d;
  logic [ADDR_W-1:0] addr_d;
  logic              done_d;
  logic              song_end;
  logic              tone_load;
  logic              tone_en;
  logic              tone_mute;
  logic              in_gap;
  logic              period_zero;

  // Pause freezes playback for exactly the cycles it is high: PAUSE with pause low
  // resumes and advances in the same cycle.
  always_comb begin
    state_d   = state;
    beat_d    = beat_cnt;
    addr_d    = addr;
    done_d    = 1'b0;
    song_end  = 1'b0;
    tone_load = 1'b0;
    tone_en   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_d = PLAY;
          beat_d  = '0;
          addr_d  = '0;
        end
      end
      PLAY, PAUSE: begin
        if (pause) begin
          state_d = PAUSE;
        end else begin
          state_d = PLAY;
          if ((beat_cnt >= TONE_BEAT) && period_zero) begin
            song_end = 1'b1;
          end else begin
            tone_load = (beat_cnt == LOAD_BEAT);
            tone_en   = (beat_cnt >= TONE_BEAT);
            if (beat_cnt == BEAT_LAST) begin
              beat_d = '0;
              if (addr != LAST_ADDR) begin
                addr_d = addr + ADDR_ONE;
              end else if (loop_en) begin
                addr_d = '0;
              end else begin
                song_end = 1'b1;
              end
            end else begin
              beat_d = beat_cnt + BEAT_ONE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (song_end) begin
      state_d = IDLE;
      addr_d  = '0;
      beat_d  = '0;
      done_d  = 1'b1;
    end

    in_gap    = ARTIC_EN && (GAP_CYCLES > 0) && (beat_d >= GAP_BEAT);
    tone_mute = !((state_d == PLAY) && (beat_d >= TONE_BEAT) && !in_gap);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      beat_cnt <= '0;
      addr     <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      beat_cnt <= beat_d;
      addr     <= addr_d;
      done     <= done_d;
    end
  end

  assign playing = (state != IDLE);

  tone_gen #(
    .NOTE_W   (NOTE_W),
    .REST_VAL (REST_VAL)
  ) u_tone_gen (
    .clk         (clk),
    .rst         (rst),
    .load        (tone_load),
    .period_in   (note),
    .enable      (tone_en),
    .mute        (tone_mute),
    .wave        (buzzer),
    .period_zero (period_zero)
  );

endmodule
